// File: rtl/bsg_link_rx_seq_checker.sv
// bsg_link_rx_seq_checker
//   Drains words from bsg_link_ddr_downstream through a valid/yumi handshake,
//   compares the sequence number carried in the top seq_width_p bits of each
//   word against the locally expected value, and forwards the payload plus a
//   mismatch tag to core logic through a small valid/ready output FIFO.
//   Mismatching words are always forwarded and tagged, never dropped.
//   Keeps a saturating mismatch counter and a one-cycle error pulse.
//
//   Optional feature macro: BSG_LINK_RX_SEQ_RESYNC_EN
//     defined   : on a mismatch the expected sequence resyncs to seq+1, so a
//                 single dropped word produces exactly one error.
//     undefined : the expected sequence free-runs (+1 per accepted word), so a
//                 drop flags every following word until the sender realigns.
module bsg_link_rx_seq_checker #(
  parameter int width_p         = 64,
  parameter int seq_width_p     = 8,
  parameter int els_p           = 2,
  parameter int err_cnt_width_p = 16
) (
  input  logic                            core_clk_i,
  input  logic                            core_link_reset_i,

  input  logic [width_p-1:0]              link_data_i,
  input  logic                            link_v_i,
  output logic                            link_yumi_o,

  output logic [width_p-seq_width_p-1:0]  data_o,
  output logic                            data_err_o,
  output logic                            v_o,
  input  logic                            ready_i,

  output logic                            seq_err_o,
  output logic [err_cnt_width_p-1:0]      err_count_o,
  output logic [seq_width_p-1:0]          expected_seq_o
);

  localparam int payload_width_lp = width_p - seq_width_p;
  localparam int addr_width_lp    = $clog2(els_p);
  localparam int ptr_width_lp     = addr_width_lp + 1;

  typedef struct packed {
    logic                        err;
    logic [payload_width_lp-1:0] data;
  } entry_s;

  entry_s                     mem_r [els_p];
  entry_s                     rd_entry;
  logic [ptr_width_lp-1:0]    wr_ptr_r, rd_ptr_r;
  logic [seq_width_p-1:0]     expected_seq_r, expected_seq_n, seq_in;
  logic [err_cnt_width_p-1:0] err_count_r;
  logic                       seq_err_r;
  logic                       full, empty, accept, pop, mismatch;

  // The extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[ptr_width_lp-1] != rd_ptr_r[ptr_width_lp-1])
              && (wr_ptr_r[addr_width_lp-1:0] == rd_ptr_r[addr_width_lp-1:0]);

  // NOTE: yumi depends only on link_v_i, registered full and reset; folding
  // ready_i in would chain a core-side combinational path into the link.
  // The cost is that a full buffer refuses a word even in a cycle it pops.
  assign link_yumi_o = link_v_i & ~full & ~core_link_reset_i;
  assign accept      = link_yumi_o;
  assign pop         = ~empty & ready_i;

  assign seq_in   = link_data_i[width_p-1 -: seq_width_p];
  assign mismatch = (seq_in != expected_seq_r);

`ifdef BSG_LINK_RX_SEQ_RESYNC_EN
  // Follow the received stream: on a match seq_in equals expected_seq_r anyway.
  assign expected_seq_n = seq_in + seq_width_p'(1);
`else
  // Free-running expectation, independent of what actually arrived.
  assign expected_seq_n = expected_seq_r + seq_width_p'(1);
`endif

  // Read/write pointer update; both may move in the same cycle.
  always_ff @(posedge core_clk_i) begin
    if (core_link_reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (accept) wr_ptr_r <= wr_ptr_r + ptr_width_lp'(1);
      if (pop)    rd_ptr_r <= rd_ptr_r + ptr_width_lp'(1);
    end
  end

  // Buffer storage write.
  // NOTE: the storage array is deliberately not reset; emptiness is fully
  // defined by the pointers, and the read side masks stale contents below.
  always_ff @(posedge core_clk_i) begin
    if (accept) begin
      mem_r[wr_ptr_r[addr_width_lp-1:0]] <= '{err: mismatch,
                                             data: link_data_i[payload_width_lp-1:0]};
    end
  end

  // Sequence tracking, error pulse and saturating error counter.
  always_ff @(posedge core_clk_i) begin
    if (core_link_reset_i) begin
      expected_seq_r <= '0;
      seq_err_r      <= 1'b0;
      err_count_r    <= '0;
    end else begin
      seq_err_r <= accept & mismatch;
      if (accept) begin
        expected_seq_r <= expected_seq_n;
        if (mismatch && !(&err_count_r)) begin
          err_count_r <= err_count_r + err_cnt_width_p'(1);
        end
      end
    end
  end

  // Head of buffer drives the core side; zeroed whenever nothing is valid.
  assign rd_entry       = mem_r[rd_ptr_r[addr_width_lp-1:0]];
  assign v_o            = ~empty;
  assign data_o         = empty ? '0 : rd_entry.data;
  assign data_err_o     = ~empty & rd_entry.err;
  assign seq_err_o      = seq_err_r;
  assign err_count_o    = err_count_r;
  assign expected_seq_o = expected_seq_r;

endmodule

// File: tb/tb_bsg_link_rx_seq_checker.sv
// Testbench for bsg_link_rx_seq_checker. A queue-based reference model tracks
// the output FIFO contents, expected sequence and error statistics; a second
// instance with a 2-bit error counter shares all inputs to cover saturation.
// Honours BSG_LINK_RX_SEQ_RESYNC_EN the same way the design does.
module tb_bsg_link_rx_seq_checker;

  localparam int W = 64;
  localparam int S = 8;
  localparam int E = 2;
  localparam int P = W - S;

  logic         clk = 1'b0;
  logic         rst, link_v, ready;
  logic [W-1:0] link_data;

  logic         yumi, v, derr, serr;
  logic [P-1:0] data;
  logic [15:0]  ecnt;
  logic [S-1:0] eseq;

  logic         yumi2, v2, derr2, serr2;
  logic [P-1:0] data2;
  logic [1:0]   ecnt2;
  logic [S-1:0] eseq2;

  always #5 clk = ~clk;

  bsg_link_rx_seq_checker #(.width_p(W), .seq_width_p(S), .els_p(E), .err_cnt_width_p(16)) dut (
    .core_clk_i(clk), .core_link_reset_i(rst),
    .link_data_i(link_data), .link_v_i(link_v), .link_yumi_o(yumi),
    .data_o(data), .data_err_o(derr), .v_o(v), .ready_i(ready),
    .seq_err_o(serr), .err_count_o(ecnt), .expected_seq_o(eseq));

  bsg_link_rx_seq_checker #(.width_p(W), .seq_width_p(S), .els_p(E), .err_cnt_width_p(2)) dut_sat (
    .core_clk_i(clk), .core_link_reset_i(rst),
    .link_data_i(link_data), .link_v_i(link_v), .link_yumi_o(yumi2),
    .data_o(data2), .data_err_o(derr2), .v_o(v2), .ready_i(ready),
    .seq_err_o(serr2), .err_count_o(ecnt2), .expected_seq_o(eseq2));

  typedef struct {
    logic         err;
    logic [P-1:0] data;
  } ent_t;

  ent_t         mq[$];      // model of the output buffer contents
  logic [W-1:0] src_q[$];   // words the upstream link still has to deliver
  int           m_exp;      // model expected sequence, 0..2^S-1
  int           m_cnt;      // model mismatch count (unsaturated)
  bit           m_serr;
  bit           gate;       // upstream willing to present a word
  int           checks = 0;
  int           failures = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int min_i(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [W-1:0] mk_word(int seq);
    logic [63:0] r;
    logic [S-1:0] s;
    r = {$urandom, $urandom};
    s = S'(seq);
    return {s, r[P-1:0]};
  endfunction

  // One clock cycle: drive link side, check yumi, advance model, check outputs.
  task automatic cycle();
    bit           acc, pop, mis;
    logic [S-1:0] sq;
    link_v    = gate && (src_q.size() > 0);
    link_data = (src_q.size() > 0) ? src_q[0] : '0;
    #1;
    acc = link_v && !rst && (mq.size() < E);
    pop = (mq.size() > 0) && ready;
    check("yumi", yumi, acc);
    check("yumi_sat", yumi2, acc);
    @(posedge clk);
    #1;
    if (rst) begin
      mq.delete();
      m_exp  = 0;
      m_cnt  = 0;
      m_serr = 0;
    end else begin
      m_serr = 0;
      if (pop) void'(mq.pop_front());
      if (acc) begin
        sq  = link_data[W-1 -: S];
        mis = (int'(sq) != m_exp);
        mq.push_back('{err: mis, data: link_data[P-1:0]});
        void'(src_q.pop_front());
        if (mis) begin
          m_serr = 1;
          m_cnt++;
        end
`ifdef BSG_LINK_RX_SEQ_RESYNC_EN
        m_exp = (int'(sq) + 1) % (1 << S);
`else
        m_exp = (m_exp + 1) % (1 << S);
`endif
      end
    end
    check("v_o", v, mq.size() > 0);
    if (mq.size() > 0) begin
      check("data_o", data, mq[0].data);
      check("data_err_o", derr, mq[0].err);
    end
    check("seq_err_o", serr, m_serr);
    check("err_count_o", ecnt, min_i(m_cnt, 65535));
    check("err_count_sat", ecnt2, min_i(m_cnt, 3));
    check("expected_seq_o", eseq, m_exp);
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  // Run with everything enabled until the model has nothing left, bounded.
  task automatic drain();
    int k = 0;
    ready = 1'b1;
    gate  = 1'b1;
    while ((mq.size() > 0 || src_q.size() > 0) && k < 2000) begin
      cycle();
      k++;
    end
  endtask

  // Hold reset for n cycles with whatever is pending upstream, then release
  // and confirm the first post-reset cycle shows all-zero outputs.
  task automatic do_reset(int n);
    rst  = 1'b1;
    gate = 1'b1;
    run(n);
    src_q.delete();
    rst    = 1'b0;
    link_v = 1'b0;
    #1;
    check("rst_v_o", v, 0);
    check("rst_data_o", data, 0);
    check("rst_data_err_o", derr, 0);
    check("rst_seq_err_o", serr, 0);
    check("rst_err_count_o", ecnt, 0);
    check("rst_expected_seq_o", eseq, 0);
    check("rst_yumi", yumi, 0);
  endtask

  initial begin
    int src_next;
    rst = 1'b1; ready = 1'b0; gate = 1'b0; link_v = 1'b0; link_data = '0;
    m_exp = 0; m_cnt = 0; m_serr = 0;

    // Initial reset with a word offered: yumi must stay low throughout.
    src_q.push_back(mk_word(0));
    do_reset(3);

    // Ten in-order words at full rate.
    ready = 1'b1;
    for (int i = 0; i < 10; i++) src_q.push_back(mk_word(i));
    drain();
    check("t1_expected_seq", eseq, 10);
    check("t1_err_count", ecnt, 0);

    // 300 in-order words: sequence field wraps 255 -> 0 without error.
    do_reset(1);
    for (int i = 0; i < 300; i++) src_q.push_back(mk_word(i));
    drain();
    check("t2_expected_seq", eseq, 44);
    check("t2_err_count", ecnt, 0);

    // Single drop: 0,1,3,4.
    do_reset(1);
    src_q.push_back(mk_word(0));
    src_q.push_back(mk_word(1));
    src_q.push_back(mk_word(3));
    src_q.push_back(mk_word(4));
    drain();
`ifdef BSG_LINK_RX_SEQ_RESYNC_EN
    check("t3_err_count", ecnt, 1);
    check("t3_expected_seq", eseq, 5);
`else
    check("t3_err_count", ecnt, 2);
    check("t3_expected_seq", eseq, 4);
`endif

    // Back-pressure: only two words fit while ready_i is low.
    do_reset(1);
    ready = 1'b0;
    for (int i = 0; i < 4; i++) src_q.push_back(mk_word(i));
    run(6);
    check("t4_v_o_held", v, 1);
    drain();

    // Randomised traffic with occasional drops and duplicates.
    do_reset(1);
    src_next = 0;
    for (int c = 0; c < 600; c++) begin
      int r;
      ready = ($urandom_range(0, 3) != 0);
      gate  = ($urandom_range(0, 3) != 0);
      if (src_q.size() < 2) begin
        r = $urandom_range(0, 9);
        if (r == 0) src_next += 1;
        else if (r == 1 && src_next > 0) src_next -= 1;
        src_q.push_back(mk_word(src_next));
        src_next++;
      end
      cycle();
    end
    drain();
    if (m_cnt >= 3) check("t5_err_count_saturated", ecnt2, 3);

    // Reset while two words are buffered and the link keeps offering.
    do_reset(1);
    ready = 1'b0;
    for (int i = 0; i < 4; i++) src_q.push_back(mk_word(i));
    run(4);
    check("t6_buffered_before_reset", v, 1);
    do_reset(1);
    src_q.push_back(mk_word(0));
    drain();
    check("t6_err_count_after", ecnt, 0);
    check("t6_expected_seq_after", eseq, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
